data_memory_line_server: RTL

- Memory-side responder for the level-1 data cache.
- On a cache miss it fetches a 4-word, 128-bit line from a word-organised backing RAM over several cycles, one word at a time, then presents the whole line atomically together with its aligned address.
- It also accepts single-word write-through stores.
- It sits between the L1 data cache and main storage, and is the producer of the cache's refill-line input.

---
 rtl/data_memory_line_server_pkg.sv | 22 ++
 rtl/data_memory_word_ram.sv | 28 ++
 rtl/data_memory_line_server.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_line_server_pkg.sv
// Shared types and constants for the L1 data-cache line server and its cache-side peers.
package data_memory_line_server_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int WORD_BITS   = 32;
    localparam int LINE_BITS   = 128;
    localparam int OFFSET_BITS = 4;

    // Filler instruction the cache miss path substitutes while a refill is outstanding.
    localparam logic [WORD_BITS-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/data_memory_word_ram.sv
// Single-port 32-bit word RAM: synchronous write, registered read-before-write output.
// Read data for the address of cycle N is visible in cycle N+1.
module data_memory_word_ram
    import data_memory_line_server_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [WORD_BITS-1:0] i_wdata,
    output logic [WORD_BITS-1:0] o_rdata
);

    logic [WORD_BITS-1:0] r_mem [MEM_WORDS];
    logic [WORD_BITS-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_line_server.sv
// Refill-line server: fetches a 4-word line one word per WORD_LATENCY cycles and presents
// it atomically, or commits a single write-through word after WORD_LATENCY cycles.
module data_memory_line_server
    import data_memory_line_server_pkg::*;
#(
    parameter int MEM_WORDS    = 1024,
    parameter int WORD_LATENCY = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    input  logic                 i_req_write,
    input  logic [31:0]          i_req_address,
    input  logic [WORD_BITS-1:0] i_req_data,
    output logic                 o_req_ready,
    output logic [LINE_BITS-1:0] o_line_out,
    output logic [31:0]          o_line_address,
    output logic                 o_line_valid,
    output logic                 o_write_done,
    output logic                 o_busy
);

    localparam int IDX_W    = $clog2(MEM_WORDS);
    localparam int LAT_W    = (WORD_LATENCY > 1) ? $clog2(WORD_LATENCY) : 1;
    localparam int BUF_BITS = WORD_BITS * (LINE_WORDS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_k;
    logic [LAT_W-1:0]      r_lat;
    logic [IDX_W-1:0]      r_line_idx;
    logic [31:0]           r_base;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [WORD_BITS-1:0]  r_wr_data;
    logic [BUF_BITS-1:0]   r_buf;
    logic [LINE_BITS-1:0]  r_line_out;
    logic [31:0]           r_line_addr;
    logic                  r_line_vld;
    logic                  r_write_done;

    logic                  w_accept;
    logic                  w_word_done;
    logic [1:0]            w_fetch_off;
    logic [IDX_W-1:0]      w_req_idx;
    logic [IDX_W-1:0]      w_req_line_idx;
    logic                  w_ram_we;
    logic [IDX_W-1:0]      w_ram_addr;
    logic [WORD_BITS-1:0]  w_rd_data;
    logic                  w_unused_addr_bits;

    assign o_req_ready        = (r_state == ST_IDLE) && i_rst_n;
    assign w_accept           = i_req_valid && o_req_ready;
    assign w_word_done        = (r_lat == LAT_W'(WORD_LATENCY - 1));
    assign w_req_idx          = i_req_address[IDX_W+1:2];
    assign w_req_line_idx     = w_req_idx & ~IDX_W'(3);
    assign w_unused_addr_bits = ^i_req_address[1:0];

    // The RAM output is registered, so the address always runs one cycle ahead of the
    // capture: on a word's final latency cycle it already points at the next word.
    assign w_fetch_off = r_k + {1'b0, w_word_done};

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = w_req_line_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = i_req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                w_ram_addr = r_line_idx | IDX_W'(w_fetch_off);
                if (w_word_done && (r_k == 2'd3)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_ram_addr = r_wr_idx;
                w_ram_we   = w_word_done;
                if (w_word_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_k          <= 2'd0;
            r_lat        <= '0;
            r_line_idx   <= '0;
            r_base       <= '0;
            r_wr_idx     <= '0;
            r_wr_data    <= '0;
            r_buf        <= '0;
            r_line_out   <= '0;
            r_line_addr  <= '0;
            r_line_vld   <= 1'b0;
            r_write_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_line_vld   <= 1'b0;
            r_write_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_k   <= 2'd0;
                        r_lat <= '0;
                        if (i_req_write) begin
                            r_wr_idx  <= w_req_idx;
                            r_wr_data <= i_req_data;
                        end else begin
                            r_base     <= line_base(i_req_address);
                            r_line_idx <= w_req_line_idx;
                        end
                    end
                end
                ST_READ: begin
                    if (w_word_done) begin
                        r_lat <= '0;
                        r_k   <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            // Last word goes straight to the output with the buffered three.
                            r_line_out  <= {w_rd_data, r_buf};
                            r_line_addr <= r_base;
                            r_line_vld  <= 1'b1;
                        end else begin
                            r_buf[WORD_BITS*r_k +: WORD_BITS] <= w_rd_data;
                        end
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_word_done) begin
                        r_lat        <= '0;
                        r_write_done <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                default: begin
                    r_lat <= '0;
                end
            endcase
        end
    end

    data_memory_word_ram #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (IDX_W)
    ) u_word_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wr_data),
        .o_rdata (w_rd_data)
    );

    assign o_line_out     = r_line_out;
    assign o_line_address = r_line_addr;
    assign o_line_valid   = r_line_vld;
    assign o_write_done   = r_write_done;
    assign o_busy         = (r_state != ST_IDLE);

endmodule
